// File: rtl/if_fetch_mem_if.sv
// Byte-wide read port between the fetch stage and the memory controller.
// The fetch stage is the master: it raises mem_req with an address and waits for mem_valid.
interface if_fetch_mem_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [7:0]  mem_data;

  modport master (output mem_req, mem_addr, input mem_valid, mem_data);
  modport slave  (input mem_req, mem_addr, output mem_valid, mem_data);
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: builds each 32-bit instruction from four little-endian byte reads,
// holds it for the IF/ID register until released, and follows EX branch redirects at any time.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [5:0]            stall,
  input  logic                  branch_flag_in,
  input  logic [31:0]           branch_addr_in,
  if_fetch_mem_if.master        mem,
  output logic [31:0]           if_pc,
  output logic [31:0]           if_inst,
  output logic                  stallreq_if
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [1:0]  r_cnt;
  logic [31:0] r_buf;
  logic [31:0] r_pend_pc;

  logic        w_req;
  logic        w_xfer;
  logic        w_unused;

  // Only stall[0] concerns the PC stage; the other bits belong to later stages.
  assign w_unused = ^stall[5:1];

  assign w_req  = (r_state == FETCH) || (r_state == FLUSH);
  assign w_xfer = w_req && mem.mem_valid;

  // Entering FLUSH leaves pc and cnt untouched, so pc+cnt is still the abandoned request's address.
  assign mem.mem_req  = w_req;
  assign mem.mem_addr = w_req ? (r_pc + {30'd0, r_cnt}) : 32'd0;
  assign if_pc        = r_pc;
  assign if_inst      = (r_state == DONE) ? r_buf : 32'd0;
  assign stallreq_if  = (r_state != DONE);

  // NOTE: all state is updated with non-blocking assignments so every branch of the
  // FSM reads the pre-edge values of r_pc/r_cnt, regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_cnt     <= 2'd0;
      r_buf     <= 32'd0;
      r_pend_pc <= 32'd0;
    end else if (rdy_in) begin
      unique case (r_state)
        IDLE: begin
          if (branch_flag_in) r_pc <= branch_addr_in;
          r_cnt   <= 2'd0;
          r_state <= FETCH;
        end

        FETCH: begin
          if (branch_flag_in) begin
            if (w_xfer) begin
              r_pc  <= branch_addr_in;
              r_cnt <= 2'd0;
            end else begin
              r_pend_pc <= branch_addr_in;
              r_state   <= FLUSH;
            end
          end else if (w_xfer) begin
            r_buf[8*r_cnt +: 8] <= mem.mem_data;
            r_cnt               <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) r_state <= DONE;
          end
        end

        FLUSH: begin
          // The outstanding read must complete on the bus before the redirect takes effect.
          if (branch_flag_in) r_pend_pc <= branch_addr_in;
          if (w_xfer) begin
            r_pc    <= branch_flag_in ? branch_addr_in : r_pend_pc;
            r_cnt   <= 2'd0;
            r_state <= FETCH;
          end
        end

        DONE: begin
          if (branch_flag_in) begin
            r_pc    <= branch_addr_in;
            r_cnt   <= 2'd0;
            r_state <= FETCH;
          end else if (!stall[0]) begin
            r_pc    <= r_pc + 32'd4;
            r_cnt   <= 2'd0;
            r_state <= FETCH;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a byte memory model answers reads, and each scenario task
// compares outputs against hand-computed values at the falling edge.
module tb_if_fetch;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [5:0]  stall;
  logic        branch_flag_in;
  logic [31:0] branch_addr_in;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if;

  int total = 0;
  int bad   = 0;

  if_fetch_mem_if mem ();

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .stall          (stall),
    .branch_flag_in (branch_flag_in),
    .branch_addr_in (branch_addr_in),
    .mem            (mem.master),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .stallreq_if    (stallreq_if)
  );

  always #5 clk_in = ~clk_in;

  // Memory contents: bytes 13,00,00,00 at 0..3, elsewhere addr[7:0] + 16*addr[11:8].
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] hi;
    hi = {a[11:8], 4'h0};
    case (a)
      32'd0:   return 8'h13;
      32'd1,
      32'd2,
      32'd3:   return 8'h00;
      default: return a[7:0] + hi;
    endcase
  endfunction

  assign mem.mem_data = mem_byte(mem.mem_addr);

  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Precondition: FETCH with cnt=0 at base; mem_valid high for four cycles then DONE.
  task automatic run_fetch(input logic [31:0] base, input logic [31:0] inst);
    mem.mem_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem.mem_addr !== base + i) begin
        bad++;
        $display("FAIL fetch_addr: got %h expected %h", mem.mem_addr, base + i);
      end
      step();
    end
    total++;
    if (if_inst !== inst) begin
      bad++;
      $display("FAIL fetch_inst: got %h expected %h", if_inst, inst);
    end
    total++;
    if (if_pc !== base || stallreq_if !== 1'b0 || mem.mem_req !== 1'b0) begin
      bad++;
      $display("FAIL fetch_done: pc=%h stallreq=%b req=%b expected pc=%h 0 0",
               if_pc, stallreq_if, mem.mem_req, base);
    end
  endtask

  // Release the PC stage for one cycle from DONE.
  task automatic advance(input logic [31:0] next_pc);
    stall = 6'd0;
    step();
    stall = 6'd1;
    total++;
    if (if_pc !== next_pc || mem.mem_addr !== next_pc || stallreq_if !== 1'b1) begin
      bad++;
      $display("FAIL advance: pc=%h addr=%h stallreq=%b expected %h %h 1",
               if_pc, mem.mem_addr, stallreq_if, next_pc, next_pc);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0; rdy_in = 1'b1; stall = 6'd1;
    branch_flag_in = 1'b0; branch_addr_in = 32'd0; mem.mem_valid = 1'b1;
    step();
    step();
    if (mem.mem_req !== 1'b0 || mem.mem_addr !== 32'd0 || if_pc !== 32'd0 ||
        if_inst !== 32'd0 || stallreq_if !== 1'b1) begin
      bad++;
      $display("FAIL reset: req=%b addr=%h pc=%h inst=%h stallreq=%b expected 0 0 0 0 1",
               mem.mem_req, mem.mem_addr, if_pc, if_inst, stallreq_if);
    end
    total++;
  endtask

  task automatic test_first_fetch();
    rst_in = 1'b1;
    step();
    chk("idle_to_fetch_req", {31'd0, mem.mem_req}, 32'd1);
    run_fetch(32'h0, 32'h0000_0013);
    advance(32'h4);  run_fetch(32'h4, 32'h0706_0504);
    advance(32'h8);  run_fetch(32'h8, 32'h0B0A_0908);
    advance(32'hC);  run_fetch(32'hC, 32'h0F0E_0D0C);
    advance(32'h10); run_fetch(32'h10, 32'h1312_1110);
  endtask

  task automatic test_stall();
    stall = 6'd1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (if_inst !== 32'h1312_1110 || if_pc !== 32'h10 || mem.mem_req !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold: inst=%h pc=%h req=%b expected 13121110 10 0",
                 if_inst, if_pc, mem.mem_req);
      end
    end
    advance(32'h14);
  endtask

  task automatic test_branch_flush();
    mem.mem_valid = 1'b1;
    step();
    step();
    chk("pre_flush_addr", mem.mem_addr, 32'h16);
    mem.mem_valid = 1'b0; branch_flag_in = 1'b1; branch_addr_in = 32'h100;
    step();
    branch_flag_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (mem.mem_req !== 1'b1 || mem.mem_addr !== 32'h16 || stallreq_if !== 1'b1) begin
        bad++;
        $display("FAIL flush_hold: req=%b addr=%h stallreq=%b expected 1 16 1",
                 mem.mem_req, mem.mem_addr, stallreq_if);
      end
      if (i < 2) step();
    end
    mem.mem_valid = 1'b1;
    step();
    chk("flush_redirect_pc", if_pc, 32'h100);
    run_fetch(32'h100, 32'h1312_1110);
  endtask

  task automatic test_double_branch();
    advance(32'h104);
    mem.mem_valid = 1'b0; branch_flag_in = 1'b1; branch_addr_in = 32'h200;
    step();
    branch_addr_in = 32'h300;
    step();
    branch_flag_in = 1'b0;
    step();
    chk("double_flush_addr", mem.mem_addr, 32'h104);
    mem.mem_valid = 1'b1;
    step();
    chk("double_branch_pc", if_pc, 32'h300);
    run_fetch(32'h300, 32'h3332_3130);
  endtask

  task automatic test_branch_done();
    stall = 6'd1; branch_flag_in = 1'b1; branch_addr_in = 32'h40;
    step();
    branch_flag_in = 1'b0;
    total++;
    if (if_inst !== 32'd0 || mem.mem_addr !== 32'h40 || if_pc !== 32'h40) begin
      bad++;
      $display("FAIL branch_done: inst=%h addr=%h pc=%h expected 0 40 40",
               if_inst, mem.mem_addr, if_pc);
    end
    run_fetch(32'h40, 32'h4342_4140);
  endtask

  task automatic test_branch_xfer();
    // Branch in FETCH coinciding with a completed transfer: byte dropped, restart at target.
    advance(32'h44);
    mem.mem_valid = 1'b1;
    step();
    chk("xfer_pre_addr", mem.mem_addr, 32'h45);
    branch_flag_in = 1'b1; branch_addr_in = 32'h200;
    step();
    branch_flag_in = 1'b0;
    chk("branch_xfer_pc", if_pc, 32'h200);
    run_fetch(32'h200, 32'h2322_2120);
  endtask

  task automatic test_rdy();
    advance(32'h204);
    mem.mem_valid = 1'b1;
    step();
    step();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem.mem_valid = (i % 2 == 0);
      step();
      total++;
      if (mem.mem_addr !== 32'h206 || if_pc !== 32'h204 || stallreq_if !== 1'b1) begin
        bad++;
        $display("FAIL rdy_freeze: addr=%h pc=%h stallreq=%b expected 206 204 1",
                 mem.mem_addr, if_pc, stallreq_if);
      end
    end
    rdy_in = 1'b1; mem.mem_valid = 1'b1;
    step();
    chk("rdy_resume_addr", mem.mem_addr, 32'h207);
    step();
    chk("rdy_resume_inst", if_inst, 32'h2726_2524);
  endtask

  task automatic test_async_reset();
    advance(32'h208);
    step();
    chk("pre_reset_addr", mem.mem_addr, 32'h209);
    #2;
    rst_in = 1'b0;
    #1;
    total++;
    if (if_pc !== 32'd0 || mem.mem_req !== 1'b0 || mem.mem_addr !== 32'd0 ||
        if_inst !== 32'd0 || stallreq_if !== 1'b1) begin
      bad++;
      $display("FAIL async_reset: pc=%h req=%b addr=%h inst=%h stallreq=%b expected 0 0 0 0 1",
               if_pc, mem.mem_req, mem.mem_addr, if_inst, stallreq_if);
    end
    @(negedge clk_in);
    rst_in = 1'b1;
    step();
    chk("post_reset_addr", mem.mem_addr, 32'h0);
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_branch_flush();
    test_double_branch();
    test_branch_done();
    test_branch_xfer();
    test_rdy();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
